// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the ctrl_seq instruction sequencer: field widths, opcodes,
// ALU operation encodings and the controller state enumeration.
package ctrl_seq_pkg;

  localparam int unsigned OpWDefault   = 8;
  localparam int unsigned AddrWDefault = 8;

  localparam int unsigned OpHlt = 0;
  localparam int unsigned OpLda = 1;
  localparam int unsigned OpSta = 2;
  localparam int unsigned OpAdd = 3;
  localparam int unsigned OpSub = 4;
  localparam int unsigned OpJmp = 5;
  localparam int unsigned OpJz  = 6;
  localparam int unsigned OpNop = 7;

  typedef enum logic [1:0] {
    AluPass = 2'b00,
    AluAdd  = 2'b01,
    AluSub  = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoadIr,
    StDecode,
    StExecAddr,
    StExecData,
    StJump,
    StHalt
  } state_e;

endpackage

// File: rtl/ctrl_seq.sv
// Moore sequencer for a simple accumulator machine: fetch, decode and execute strobes
// for the PC, IR, memory and accumulator, with a sticky halt/illegal-opcode state.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OP_W   = OpWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            run,
  input  logic [OP_W-1:0] ir_opcode,
  input  logic            mem_ready,
  input  logic            acc_zero,
  output logic            pc_valid,
  output logic            ir_valid,
  output logic            mem_valid,
  output logic            acc_valid,
  output logic            pc_load,
  output logic            pc_inc,
  output logic            ir_load,
  output logic            acc_load,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            err
);

  localparam logic [OP_W-1:0] HltOp = OP_W'(OpHlt);
  localparam logic [OP_W-1:0] LdaOp = OP_W'(OpLda);
  localparam logic [OP_W-1:0] StaOp = OP_W'(OpSta);
  localparam logic [OP_W-1:0] AddOp = OP_W'(OpAdd);
  localparam logic [OP_W-1:0] SubOp = OP_W'(OpSub);
  localparam logic [OP_W-1:0] JmpOp = OP_W'(OpJmp);
  localparam logic [OP_W-1:0] JzOp  = OP_W'(OpJz);
  localparam logic [OP_W-1:0] NopOp = OP_W'(OpNop);

  // The address field is decoded by the datapath, not here.
  logic unused_addr_w;
  assign unused_addr_w = ^ADDR_W;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StLoadIr;
      StLoadIr: state_d = StDecode;
      StDecode: begin
        op_d = ir_opcode;
        case (ir_opcode)
          HltOp:                      state_d = StHalt;
          LdaOp, StaOp, AddOp, SubOp: state_d = StExecAddr;
          JmpOp:                      state_d = StJump;
          JzOp:                       state_d = acc_zero ? StJump : StFetch;
          NopOp:                      state_d = StFetch;
          default: begin
            state_d = StHalt;
            err_d   = 1'b1;
          end
        endcase
      end
      StExecAddr: begin
        if (mem_ready) state_d = (op_q == StaOp) ? StFetch : StExecData;
      end
      StExecData: state_d = StFetch;
      StJump:     state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StIdle;
    endcase
  end

  // Strobes depend only on registered state; op_q selects read/write and ALU mode.
  always_comb begin
    pc_valid  = 1'b0;
    ir_valid  = 1'b0;
    mem_valid = 1'b0;
    acc_valid = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    acc_load  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    alu_op    = AluPass;
    halted    = 1'b0;
    case (state_q)
      StFetch: begin
        pc_valid = 1'b1;
        mem_rd   = 1'b1;
      end
      StLoadIr: begin
        mem_valid = 1'b1;
        ir_load   = 1'b1;
        pc_inc    = 1'b1;
      end
      StExecAddr: begin
        ir_valid = 1'b1;
        if (op_q == StaOp) mem_wr = 1'b1;
        else               mem_rd = 1'b1;
      end
      StExecData: begin
        mem_valid = 1'b1;
        acc_load  = 1'b1;
        if (op_q == AddOp)      alu_op = AluAdd;
        else if (op_q == SubOp) alu_op = AluSub;
        else                    alu_op = AluPass;
      end
      StJump: begin
        ir_valid = 1'b1;
        pc_load  = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OP_W, default 8, opcode field width (ir_bus[OP_W+ADDR_W-1:ADDR_W]).
REQ-002 Parameter ADDR_W, default 8, address field width (ir_bus[ADDR_W-1:0]).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  start request; sampled in IDLE only.
REQ-006 ir_opcode  input  OP_W  opcode field from instruction register output.
REQ-007 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-008 acc_zero  input  1  accumulator == 0 flag.
REQ-009 pc_valid, ir_valid, mem_valid, acc_valid  output  1 each  tri-state bus drive enables.
REQ-010 pc_load, pc_inc, ir_load, acc_load  output  1 each  register load/increment strobes.
REQ-011 mem_rd, mem_wr  output  1 each  memory read/write request.
REQ-012 alu_op  output  2  00 pass, 01 add, 10 sub.
REQ-013 halted  output  1  high in HALT; err  output  1  high when halt was caused by an illegal opcode.

Function
REQ-014 States: IDLE, FETCH, LOAD_IR, DECODE, EXEC_ADDR, EXEC_DATA, JUMP, HALT.
REQ-015 Outputs are Moore, decoded from the state register only (except err, a register).
REQ-016 At most one of pc_valid, ir_valid, mem_valid, acc_valid is high in any cycle.
REQ-017 IDLE: all outputs 0; run=1 -> FETCH.
REQ-018 FETCH: pc_valid=1, mem_rd=1; stay while mem_ready=0; mem_ready=1 -> LOAD_IR.
REQ-019 LOAD_IR: mem_valid=1, ir_load=1, pc_inc=1; -> DECODE unconditionally.
REQ-020 DECODE: no strobes; branch on ir_opcode: 0x00 HLT -> HALT; 0x01 LDA, 0x02 STA, 0x03 ADD, 0x04 SUB -> EXEC_ADDR; 0x05 JMP -> JUMP; 0x06 JZ -> JUMP if acc_zero=1 else FETCH; 0x07 NOP -> FETCH; any other -> HALT with err set.
REQ-021 Opcode is latched into an internal register in DECODE; later states use the latched value, not ir_opcode.
REQ-022 EXEC_ADDR: ir_valid=1; mem_rd=1 for LDA/ADD/SUB, mem_wr=1 for STA; stay while mem_ready=0; mem_ready=1 -> EXEC_DATA for LDA/ADD/SUB, -> FETCH for STA.
REQ-023 STA data path: acc_valid is not used during EXEC_ADDR; memory captures acc via its dedicated write port.
REQ-024 EXEC_DATA: mem_valid=1, acc_load=1, alu_op = 00/01/10 for LDA/ADD/SUB; -> FETCH.
REQ-025 JUMP: ir_valid=1, pc_load=1; -> FETCH.
REQ-026 HALT: halted=1, all other strobes 0; exits only via reset; run ignored.
REQ-027 Minimum cycle counts with mem_ready tied high: NOP 3, JMP 4, STA 4, LDA/ADD/SUB 5 (FETCH to next FETCH).
REQ-028 alu_op is 00 in every state other than EXEC_DATA.

Reset
REQ-029 nrst=0 immediately forces state IDLE, latched opcode 0, err 0; all outputs 0 while asserted, including mid-handshake.
REQ-030 Deassertion is not required to be synchronised inside this block; first transition is evaluated on the first rising clk with nrst=1.

Structure
REQ-031 Shared package holds OP_W, ADDR_W defaults, opcode constants (HLT..NOP), alu_op encodings, and the state enumeration.
REQ-032 Single module, no sub-modules; one state register, one next-state process, one output decode process.

Verification
REQ-033 Program NOP,HLT with mem_ready=1, run pulse -> FETCH->LOAD_IR->DECODE x2, halted=1 at cycle 7 after run, err=0.
REQ-034 LDA 0x10 with mem_ready delayed 3 cycles in both accesses -> FETCH held 4 cycles, EXEC_ADDR held 4 cycles with ir_valid=1, mem_rd=1, then acc_load=1 alu_op=00 for one cycle.
REQ-035 JZ with acc_zero=1 -> JUMP with pc_load=1, ir_valid=1; repeat with acc_zero=0 -> DECODE directly to FETCH, no pc_load.
REQ-036 Opcode 0xFF -> HALT, halted=1, err=1; run pulses afterwards cause no state change.
REQ-037 nrst asserted during EXEC_ADDR of STA with mem_wr=1 -> mem_wr and ir_valid drop without waiting for clk; state IDLE, err=0.
REQ-038 Random legal programs with random mem_ready stalls -> bus-enable one-hot-or-zero assertion (REQ-016) never fails.
